frv_rng_lfsr: RTL and testbench



---
 rtl/frv_rng_lfsr_pkg.sv | 35 +++
 rtl/frv_rng_lfsr_step.sv | 13 +
 rtl/frv_rng_lfsr.sv | 146 ++++++++++++++
 tb/tb_frv_rng_lfsr.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/frv_rng_lfsr_pkg.sv
// Shared constants and types for the request/response LFSR random source.
package frv_rng_lfsr_pkg;

    localparam logic [2:0]  RNG_IF_NO_INIT        = 3'b000;
    localparam logic [2:0]  RNG_IF_INIT_UNHEALTHY = 3'b100;
    localparam logic [2:0]  RNG_IF_INIT_HEALTHY   = 3'b101;

    localparam int          RNG_OP_SEED = 0;
    localparam int          RNG_OP_SAMP = 1;
    localparam int          RNG_OP_TEST = 2;

    localparam logic [31:0] RNG_LFSR_TAPS = 32'h80200003;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } rng_state_t;

    typedef enum logic [1:0] {
        OP_TEST,
        OP_SEED,
        OP_SAMP
    } rng_op_t;

    // Anything that is not exactly one-hot seed or samp behaves as a test.
    function automatic rng_op_t decode_op(input logic [2:0] op);
        rng_op_t r;
        r = OP_TEST;
        if (op == (3'b001 << RNG_OP_SEED))      r = OP_SEED;
        else if (op == (3'b001 << RNG_OP_SAMP)) r = OP_SAMP;
        return r;
    endfunction

endpackage

// File: rtl/frv_rng_lfsr_step.sv
// One Galois LFSR step: shift right, fold taps in when the outgoing bit is set.
module frv_rng_lfsr_step
    import frv_rng_lfsr_pkg::*;
#(
    parameter logic [31:0] TAPS = RNG_LFSR_TAPS
) (
    input  logic [31:0] cur,
    output logic [31:0] nxt
);

    assign nxt = (cur >> 1) ^ (cur[0] ? TAPS : 32'h0);

endmodule

// File: rtl/frv_rng_lfsr.sv
// Request/response RNG source: 32-bit Galois LFSR with seed counting, health
// status and a programmable response latency. One transaction in flight.
module frv_rng_lfsr
    import frv_rng_lfsr_pkg::*;
#(
    parameter int unsigned SEED_COUNT  = 2,
    parameter int unsigned RSP_LATENCY = 1,
    parameter logic [31:0] LFSR_INIT   = 32'h00000001
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        rng_req_valid,
    input  logic [2:0]  rng_req_op,
    input  logic [31:0] rng_req_data,
    output logic        rng_req_ready,
    output logic        rng_rsp_valid,
    output logic [2:0]  rng_rsp_status,
    output logic [31:0] rng_rsp_data,
    input  logic        rng_rsp_ready
);

    localparam logic [3:0] SEED_MAX = 4'(SEED_COUNT);
    localparam logic [3:0] LAT_LOAD = 4'((RSP_LATENCY > 0) ? RSP_LATENCY - 1 : 0);
    localparam bit         NO_WAIT  = (RSP_LATENCY == 0);

    rng_state_t  state, state_nxt;
    rng_op_t     op_q, op_sel;
    logic [31:0] data_q, data_sel;
    logic [3:0]  lat_cnt;
    logic [31:0] lfsr, lfsr_stepped, lfsr_nxt, seed_mix;
    logic [3:0]  seed_cnt, seed_cnt_nxt;
    logic [2:0]  status, status_nxt;
    logic [31:0] rsp_data_nxt;
    logic        accept, apply, rsp_hs;

    frv_rng_lfsr_step u_step (
        .cur (lfsr),
        .nxt (lfsr_stepped)
    );

    assign accept = rng_req_ready && rng_req_valid;
    assign rsp_hs = rng_rsp_valid && rng_rsp_ready;

    // With zero latency the op is applied on the accept edge, straight from the request.
    assign op_sel   = (state == ST_IDLE) ? decode_op(rng_req_op) : op_q;
    assign data_sel = (state == ST_IDLE) ? rng_req_data : data_q;
    assign apply    = (state == ST_IDLE && accept && NO_WAIT) ||
                      (state == ST_BUSY && lat_cnt == 4'd0);
    assign seed_mix = lfsr ^ data_sel;

    always_comb begin
        lfsr_nxt     = lfsr;
        seed_cnt_nxt = seed_cnt;
        status_nxt   = status;
        rsp_data_nxt = 32'h0;
        case (op_sel)
            OP_SEED: begin
                if (seed_mix == 32'h0) begin
                    lfsr_nxt     = LFSR_INIT;
                    seed_cnt_nxt = 4'd0;
                    status_nxt   = RNG_IF_INIT_UNHEALTHY;
                end else begin
                    lfsr_nxt     = seed_mix;
                    seed_cnt_nxt = (seed_cnt >= SEED_MAX) ? SEED_MAX : 4'(seed_cnt + 4'd1);
                    status_nxt   = (seed_cnt_nxt == SEED_MAX) ? RNG_IF_INIT_HEALTHY
                                                              : RNG_IF_INIT_UNHEALTHY;
                end
            end
            OP_SAMP: begin
                if (status == RNG_IF_INIT_HEALTHY) begin
                    rsp_data_nxt = lfsr;
                    lfsr_nxt     = lfsr_stepped;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = NO_WAIT ? ST_RESP : ST_BUSY;
            ST_BUSY: if (lat_cnt == 4'd0) state_nxt = ST_RESP;
            ST_RESP: if (rng_rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            op_q    <= OP_TEST;
            data_q  <= 32'h0;
            lat_cnt <= 4'd0;
        end else if (accept) begin
            op_q    <= decode_op(rng_req_op);
            data_q  <= rng_req_data;
            lat_cnt <= LAT_LOAD;
        end else if (state == ST_BUSY && lat_cnt != 4'd0) begin
            lat_cnt <= lat_cnt - 4'd1;
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            lfsr     <= LFSR_INIT;
            seed_cnt <= 4'd0;
            status   <= RNG_IF_NO_INIT;
        end else if (apply) begin
            lfsr     <= lfsr_nxt;
            seed_cnt <= seed_cnt_nxt;
            status   <= status_nxt;
        end
    end

    // Response fields are captured once and held until the consumer takes them.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            rng_req_ready  <= 1'b1;
            rng_rsp_valid  <= 1'b0;
            rng_rsp_status <= RNG_IF_NO_INIT;
            rng_rsp_data   <= 32'h0;
        end else begin
            if (accept) begin
                rng_req_ready <= 1'b0;
            end
            if (apply) begin
                rng_rsp_valid  <= 1'b1;
                rng_rsp_status <= status_nxt;
                rng_rsp_data   <= rsp_data_nxt;
            end else if (state == ST_RESP && rsp_hs) begin
                rng_rsp_valid <= 1'b0;
                rng_rsp_data  <= 32'h0;
                rng_req_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frv_rng_lfsr.sv
// Scoreboard bench: two instances (latency 1 and 0), directed ops with
// hand-computed responses, monitor checks timing, stability and contents.
module tb_frv_rng_lfsr;

    logic        g_clk;
    logic        g_reset;
    logic        req_valid [2];
    logic [2:0]  req_op    [2];
    logic [31:0] req_data  [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [2:0]  rsp_status[2];
    logic [31:0] rsp_data  [2];
    logic        rsp_ready [2];

    typedef struct {
        int          k;
        logic [2:0]  st;
        logic [31:0] dt;
        int          due;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   bp_cyc = 0;
    int   vc [2];
    bit   rdy_next [2];
    bit   done = 0;

    frv_rng_lfsr #(.RSP_LATENCY(1)) dut0 (
        .g_clk(g_clk), .g_reset(g_reset),
        .rng_req_valid(req_valid[0]), .rng_req_op(req_op[0]), .rng_req_data(req_data[0]),
        .rng_req_ready(req_ready[0]), .rng_rsp_valid(rsp_valid[0]),
        .rng_rsp_status(rsp_status[0]), .rng_rsp_data(rsp_data[0]),
        .rng_rsp_ready(rsp_ready[0])
    );

    frv_rng_lfsr #(.RSP_LATENCY(0)) dut1 (
        .g_clk(g_clk), .g_reset(g_reset),
        .rng_req_valid(req_valid[1]), .rng_req_op(req_op[1]), .rng_req_data(req_data[1]),
        .rng_req_ready(req_ready[1]), .rng_rsp_valid(rsp_valid[1]),
        .rng_rsp_status(rsp_status[1]), .rng_rsp_data(rsp_data[1]),
        .rng_rsp_ready(rsp_ready[1])
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;
    always @(posedge g_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got timeout/none want event (cycle %0d)", nm, cyc);
    endtask

    // Monitor: compares every presented response against the queue head.
    always @(negedge g_clk) begin
        if (g_reset) begin
            vc[0] = 0; vc[1] = 0;
            rdy_next[0] = 0; rdy_next[1] = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (rdy_next[k]) begin
                    chk($sformatf("ready_after_hs%0d", k), {31'h0, req_ready[k]}, 32'h1);
                    rdy_next[k] = 0;
                end
                if (rsp_valid[k]) begin
                    if (q.size() == 0 || q[0].k != k) begin
                        fail($sformatf("unexpected_rsp%0d", k));
                        rsp_ready[k] = 1'b1;
                    end else begin
                        vc[k]++;
                        if (vc[k] == 1)
                            chk($sformatf("latency%0d", k), cyc, q[0].due);
                        chk($sformatf("status%0d", k), {29'h0, rsp_status[k]}, {29'h0, q[0].st});
                        chk($sformatf("data%0d", k), rsp_data[k], q[0].dt);
                        chk($sformatf("busy_ready%0d", k), {31'h0, req_ready[k]}, 32'h0);
                        if (vc[k] > bp_cyc) begin
                            rsp_ready[k] = 1'b1;
                            void'(q.pop_front());
                            vc[k] = 0;
                            rdy_next[k] = 1;
                            done = 1;
                        end else begin
                            rsp_ready[k] = 1'b0;
                        end
                    end
                end else begin
                    rsp_ready[k] = 1'b0;
                end
            end
        end
    end

    // Issue one request and wait for its response handshake; hold keeps
    // req_valid high with changing seed requests while the response is pending.
    task automatic issue(input int k, input logic [2:0] op, input logic [31:0] d,
                         input logic [2:0] es, input logic [31:0] ed,
                         input int bp, input bit hold);
        int   w;
        exp_t e;
        req_op[k] = op; req_data[k] = d; req_valid[k] = 1'b1;
        w = 0;
        forever begin
            @(negedge g_clk);
            if (req_ready[k]) break;
            if (++w > 50) begin
                fail("accept_timeout");
                req_valid[k] = 1'b0;
                return;
            end
        end
        e.k = k; e.st = es; e.dt = ed; e.due = cyc + 1 + ((k == 0) ? 1 : 0);
        q.push_back(e);
        bp_cyc = bp;
        done = 0;
        @(posedge g_clk); #1;
        if (!hold) req_valid[k] = 1'b0;
        w = 0;
        while (!done && w < 100) begin
            if (hold) begin
                req_op[k] = 3'b001;
                req_data[k] = $urandom;
            end
            @(posedge g_clk); #1;
            w++;
        end
        req_valid[k] = 1'b0;
        bp_cyc = 0;
        if (!done) begin
            fail("rsp_timeout");
            q.delete();
        end
    endtask

    task automatic chk_idle(input int k, input string nm);
        chk({nm, "_ready"},  {31'h0, req_ready[k]}, 32'h1);
        chk({nm, "_valid"},  {31'h0, rsp_valid[k]}, 32'h0);
        chk({nm, "_status"}, {29'h0, rsp_status[k]}, 32'h0);
        chk({nm, "_data"},   rsp_data[k], 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        g_reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 0; req_op[k] = 0; req_data[k] = 0; rsp_ready[k] = 0;
        end
        repeat (3) @(posedge g_clk);
        #1;
        chk_idle(0, "rst0");
        chk_idle(1, "rst1");
        g_reset = 1'b0;
        @(posedge g_clk); #1;

        // latency 1 instance: test, seeds, samples with backpressure
        issue(0, 3'b100, 32'h0,        3'b000, 32'h0,        0, 0);
        issue(0, 3'b001, 32'hDEADBEEE, 3'b100, 32'h0,        0, 0);
        issue(0, 3'b001, 32'h00000000, 3'b101, 32'h0,        0, 0);
        issue(0, 3'b010, 32'h0,        3'b101, 32'hDEADBEEF, 0, 0);
        issue(0, 3'b010, 32'h0,        3'b101, 32'hEF76DF74, 5, 1);
        issue(0, 3'b010, 32'h0,        3'b101, 32'h77BB6FBA, 0, 0);
        issue(0, 3'b100, 32'h0,        3'b101, 32'h0,        0, 0);

        // latency 0 instance: invalid ops, degenerate seed, recovery
        issue(1, 3'b011, 32'hFFFFFFFF, 3'b000, 32'h0,        0, 0);
        issue(1, 3'b001, 32'h00000001, 3'b100, 32'h0,        0, 0);
        issue(1, 3'b010, 32'h0,        3'b100, 32'h0,        0, 0);
        issue(1, 3'b000, 32'h0,        3'b100, 32'h0,        0, 0);
        issue(1, 3'b001, 32'h12345678, 3'b100, 32'h0,        0, 0);
        issue(1, 3'b001, 32'h00000000, 3'b101, 32'h0,        0, 0);
        issue(1, 3'b010, 32'h0,        3'b101, 32'h12345679, 3, 1);
        issue(1, 3'b110, 32'h0,        3'b101, 32'h0,        0, 0);

        // seed counter clears on a degenerate seed
        issue(0, 3'b001, 32'h00000005, 3'b101, 32'h0,        0, 0);
        g_reset = 1'b1;
        @(posedge g_clk); #1;
        g_reset = 1'b0;
        @(posedge g_clk); #1;
        issue(0, 3'b001, 32'h00000005, 3'b100, 32'h0,        0, 0);
        issue(0, 3'b001, 32'h00000004, 3'b100, 32'h0,        0, 0);
        issue(0, 3'b001, 32'h00000002, 3'b100, 32'h0,        0, 0);
        issue(0, 3'b001, 32'h00000000, 3'b101, 32'h0,        0, 0);
        issue(0, 3'b010, 32'h0,        3'b101, 32'h00000003, 0, 0);

        // async reset in the middle of a busy samp
        req_op[0] = 3'b010; req_data[0] = 32'h0; req_valid[0] = 1'b1;
        w = 0;
        do begin
            @(negedge g_clk);
            w++;
        end while (!req_ready[0] && w < 50);
        if (!req_ready[0]) fail("mid_accept_timeout");
        @(posedge g_clk); #1;
        req_valid[0] = 1'b0;
        #2 g_reset = 1'b1;
        #1;
        chk_idle(0, "midrst");
        @(posedge g_clk);
        @(posedge g_clk); #1;
        g_reset = 1'b0;
        @(posedge g_clk); #1;
        chk_idle(0, "postrst");
        issue(0, 3'b010, 32'h0,        3'b000, 32'h0,        0, 0);
        issue(1, 3'b010, 32'h0,        3'b000, 32'h0,        0, 0);

        repeat (4) @(posedge g_clk);
        #1;
        chk("queue_empty", q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
